// File: rtl/regfile_wb_arbiter_pkg.sv
// Purpose: shared constants and helpers for the register-file writeback arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Fixed requester slots on the writeback bus
  localparam int WB_SRC_ALU  = 0;
  localparam int WB_SRC_LOAD = 1;
  localparam int WB_SRC_ACC  = 2;

  // Per-source grant counter geometry
  localparam int GRANT_CNT_W = 16;
  localparam logic [GRANT_CNT_W-1:0] GRANT_CNT_MAX = 16'hFFFF;

  // Round-robin successor: the slot after idx, wrapping at n
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_priority_pick.sv
// Purpose: rotate the request vector to start at ptr, then pick the first set bit.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is accepted.
module rr_priority_pick #(
  parameter int N     = 3,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] idx,
  output logic             any_valid
);

  logic [N-1:0] rot;
  int           rot_j;
  int           first_k;
  int           win_i;
  logic         found;

  // Rotate so that bit 0 of rot is the request at slot ptr
  always_comb begin
    rot   = '0;
    rot_j = 0;
    for (int k = 0; k < N; k++) begin
      rot_j = int'(ptr) + k;
      if (rot_j >= N) rot_j = rot_j - N;
      rot[k] = valid[rot_j];
    end
  end

  // Find the first set bit of the rotated vector and map it back to a slot
  always_comb begin
    found   = 1'b0;
    first_k = 0;
    for (int k = 0; k < N; k++) begin
      if (rot[k] && !found) begin
        found   = 1'b1;
        first_k = k;
      end
    end
    win_i = int'(ptr) + first_k;
    if (win_i >= N) win_i = win_i - N;
    grant = '0;
    if (found) grant[win_i] = 1'b1;
    idx       = PTR_W'(win_i);
    any_valid = found;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Purpose: round-robin share of the single register-file write port among NUM_REQ sources
//          (optional per-source grant counters under `REGFILE_WB_GRANT_CNT_EN).
// Latency: 1 cycle from accepted request to reg_write/write_reg/write_data.
// Backpressure: combinational one-hot req_ready; hold or reset forces it to zero.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = XLEN,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      hold,
  output logic                      reg_write,
  output logic [ADDR_W-1:0]         write_reg,
  output logic [DATA_W-1:0]         write_data,
  output logic                      wb_busy
`ifdef REGFILE_WB_GRANT_CNT_EN
  ,
  output logic [NUM_REQ*GRANT_CNT_W-1:0] grant_cnt
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] pick_grant;
  logic [PTR_W-1:0]   win_idx;
  logic               any_valid;
  logic               accept;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_data;

  rr_priority_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .grant     (pick_grant),
    .idx       (win_idx),
    .any_valid (any_valid)
  );

  // Accept the pick only when the pipeline is not stalled and not in reset
  always_comb begin
    accept    = any_valid && !hold && !reset;
    req_ready = accept ? pick_grant : '0;
    win_addr  = req_addr[win_idx*ADDR_W +: ADDR_W];
    win_data  = req_data[win_idx*DATA_W +: DATA_W];
  end

  // Register the winning write and advance the pointer past the winner;
  // writes to x0 consume a grant but never reach the register file
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      rr_ptr     <= '0;
    end else begin
      reg_write <= accept && (win_addr != ADDR_W'(REG_ZERO));
      if (accept) begin
        rr_ptr <= PTR_W'(rr_next(int'(win_idx), NUM_REQ));
        if (win_addr != ADDR_W'(REG_ZERO)) begin
          write_reg  <= win_addr;
          write_data <= win_data;
        end
      end
    end
  end

  assign wb_busy = reg_write;

`ifdef REGFILE_WB_GRANT_CNT_EN
  logic [GRANT_CNT_W-1:0] cnt_q [NUM_REQ];

  // Saturating count of accepted transfers per source, x0 drops included
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reset) begin
        cnt_q[i] <= '0;
      end else if (accept && (win_idx == PTR_W'(i)) && (cnt_q[i] != GRANT_CNT_MAX)) begin
        cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_pack
    assign grant_cnt[g*GRANT_CNT_W +: GRANT_CNT_W] = cnt_q[g];
  end
`endif

endmodule
